uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clk_50m frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_WIDTH, default 8, stored word width; only 8 is supported.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two, >= 4.
REQ-005 SHALL have port clk_50m  input  1  system clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port fifo_rd_en  input  1  pop request.
REQ-009 SHALL have port fifo_data_out  output  FIFO_WIDTH  popped byte.
REQ-010 SHALL have port fifo_empty  output  1  no stored bytes.
REQ-011 SHALL have port fifo_full  output  1  FIFO_DEPTH bytes stored.
REQ-012 SHALL have port fifo_almost_full  output  1  count >= FIFO_DEPTH-2.
REQ-013 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-014 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-015 SHALL have port err_clr  input  1  single-cycle clear of overrun and frame_err.

Function
REQ-016 SHALL synchronise rx through two flip-flops (reset to 1); all logic below uses the synchronised value.
REQ-017 SHALL generate a 16x oversample tick: counter 0..DIV-1, DIV = CLK_HZ/(UART_BAUD*16) (integer, 27 at defaults), tick one cycle at DIV-1, free-running.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: on synchronised falling edge (1 then 0), clear tick-phase count to 0, go START.
REQ-020 START: at 8th tick (phase 7), if rx = 0 go DATA with phase 0, bit index 0; else go IDLE (glitch rejected, nothing recorded).
REQ-021 DATA: every 16th tick sample rx into shift register LSB first; after bit index 7, go STOP.
REQ-022 STOP: at 16th tick sample rx; if 1 and FIFO not full, push byte; if 1 and full, drop byte and set overrun; if 0, drop byte, set frame_err; then go IDLE.
REQ-023 A frame whose stop bit is low SHALL NOT retrigger until rx returns high and falls again (edge detect, not level).
REQ-024 FIFO SHALL be circular, pointers log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty from pointer compare; flags combinational from registered pointers.
REQ-025 Pop: on edge with fifo_rd_en=1 and fifo_empty=0, fifo_data_out registers head byte (valid the following cycle), read pointer advances.
REQ-026 fifo_rd_en while empty SHALL be ignored; fifo_data_out holds previous value.
REQ-027 Simultaneous push and pop when not full and not empty: both occur, count unchanged.
REQ-028 Push when full SHALL be dropped and set overrun even if a pop occurs on the same edge.
REQ-029 Pop and push on empty FIFO same edge: pop ignored, push accepted, fifo_empty deasserts next cycle.
REQ-030 err_clr SHALL clear both sticky flags; a set event on the same edge SHALL win.
REQ-031 Push-to-fifo_empty-low latency SHALL be 1 cycle after the stop-bit sample edge.

Reset
REQ-032 Reset SHALL force: FSM IDLE, tick counter 0, synchroniser 1, pointers 0, fifo_data_out 0, fifo_empty 1, fifo_full 0, fifo_almost_full 0, overrun 0, frame_err 0.
REQ-033 Reset mid-frame SHALL discard the partial byte; after release a full valid frame SHALL be received correctly.

Verification
REQ-034 Send 0x55 then 0xA3 at 115200 baud, 8N1 -> fifo_empty falls, two pops return 0x55 then 0xA3, no flags set.
REQ-035 rx low pulse of 5 oversample ticks (~2.7 us) -> no push, FSM back to IDLE, fifo_empty stays 1.
REQ-036 Frame 0x3C with stop bit 0 -> frame_err=1, no push; err_clr pulse -> frame_err=0; next good frame 0x11 received.
REQ-037 Send 17 bytes 0x00..0x10 with no pops -> fifo_full after 16th, fifo_almost_full after 14th, overrun=1, pops return 0x00..0x0F, then fifo_empty=1.
REQ-038 Assert reset during bit 4 of 0xF0 -> all outputs at reset values; next frame 0x81 popped as 0x81.
REQ-039 FIFO holding 1 byte, pop on the same edge as a push -> count stays 1, popped and stored bytes in order.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a circular byte FIFO.
// Sticky overrun/frame error flags, cleared by err_clr.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int UART_BAUD  = 115200,
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_50m,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  fifo_rd_en,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_almost_full,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int DIV = CLK_HZ / (UART_BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                  rx_m_q, rx_s_q, rx_prev_q;
    logic [DW-1:0]         div_q, div_d;
    logic                  tick;
    logic [1:0]            state_q, state_d;
    logic [3:0]            phase_q, phase_d;
    logic [2:0]            bit_q, bit_d;
    logic [FIFO_WIDTH-1:0] shift_q, shift_d;
    logic                  push_req, stop_bad;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  ovr_q, ovr_d, ferr_q, ferr_d;
    logic                  push, pop;

    assign tick  = (div_q == DW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Edge, not level: a low line after a bad stop bit must rise first
                if (rx_prev_q && !rx_s_q) begin
                    phase_d = 4'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (phase_q == 4'd7) begin
                        phase_d = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    phase_d = phase_q + 4'd1;
                    if (phase_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[FIFO_WIDTH-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    phase_d = phase_q + 4'd1;
                    if (phase_q == 4'd15) begin
                        push_req = rx_s_q;
                        stop_bad = !rx_s_q;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign count      = wptr_q - rptr_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_almost_full = (count >= (AW+1)'(FIFO_DEPTH - 2));

    // Decisions use registered flags, so a same-edge pop never frees a slot
    assign push = push_req && !fifo_full;
    assign pop  = fifo_rd_en && !fifo_empty;

    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        dout_d = pop ? mem_q[rptr_q[AW-1:0]] : dout_q;
        ovr_d  = (push_req && fifo_full) || (ovr_q && !err_clr);
        ferr_d = stop_bad || (ferr_q && !err_clr);
    end

    always_ff @(posedge clk_50m) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            state_q   <= S_IDLE;
            phase_q   <= 4'd0;
            bit_q     <= 3'd0;
            shift_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            dout_q    <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_m_q    <= rx;
            rx_s_q    <= rx_m_q;
            rx_prev_q <= rx_s_q;
            div_q     <= div_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            dout_q    <= dout_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign fifo_data_out = dout_q;
    assign overrun       = ovr_q;
    assign frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 115200 baud.
// CLK_HZ is scaled so one oversample tick is 4 clocks (64 clocks per bit).
module tb_uart_rx_fifo;

    localparam int DIVT = 4;
    localparam int BIT  = 64;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       fifo_rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] fifo_data_out;
    logic       fifo_empty, fifo_full, fifo_almost_full;
    logic       overrun, frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_rx_fifo #(
        .CLK_HZ    (7372800),
        .UART_BAUD (115200),
        .FIFO_WIDTH(8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_50m         (clk_50m),
        .reset           (reset),
        .rx              (rx),
        .fifo_rd_en      (fifo_rd_en),
        .err_clr         (err_clr),
        .fifo_data_out   (fifo_data_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .overrun         (overrun),
        .frame_err       (frame_err)
    );

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    // Called at a negedge; returns at a negedge exactly 10 bit times later
    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk_50m);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk_50m);
        end
        rx = stop;
        repeat (BIT) @(negedge clk_50m);
        rx = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        fifo_rd_en = 1'b1;
        @(negedge clk_50m);
        fifo_rd_en = 1'b0;
        d = fifo_data_out;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50m);
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
            fifo_almost_full !== 1'b0 || overrun !== 1'b0 ||
            frame_err !== 1'b0 || fifo_data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: e=%b f=%b af=%b o=%b fe=%b d=%h",
                     fifo_empty, fifo_full, fifo_almost_full,
                     overrun, frame_err, fifo_data_out);
        end
        reset = 1'b0;
        repeat (BIT) @(negedge clk_50m);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        send_byte(8'h55, 1'b1);
        total++;
        if (fifo_empty !== 1'b0) begin
            bad++;
            $display("FAIL basic_not_empty: got %b want 0", fifo_empty);
        end
        send_byte(8'hA3, 1'b1);
        repeat (4) @(negedge clk_50m);
        pop_byte(d);
        total++;
        if (d !== 8'h55) begin
            bad++;
            $display("FAIL basic_pop0: got %h want 55", d);
        end
        pop_byte(d);
        total++;
        if (d !== 8'hA3) begin
            bad++;
            $display("FAIL basic_pop1: got %h want a3", d);
        end
        total++;
        if (fifo_empty !== 1'b1 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_flags: e=%b o=%b fe=%b want 1 0 0",
                     fifo_empty, overrun, frame_err);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (5 * DIVT) @(negedge clk_50m);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk_50m);
        total++;
        if (fifo_empty !== 1'b1 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL glitch: e=%b fe=%b want 1 0", fifo_empty, frame_err);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        send_byte(8'h3C, 1'b0);
        repeat (BIT) @(negedge clk_50m);
        total++;
        if (frame_err !== 1'b1 || fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL ferr_set: fe=%b e=%b want 1 1", frame_err, fifo_empty);
        end
        err_clr = 1'b1;
        @(negedge clk_50m);
        err_clr = 1'b0;
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL ferr_clr: got %b want 0", frame_err);
        end
        send_byte(8'h11, 1'b1);
        pop_byte(d);
        total++;
        if (d !== 8'h11 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL ferr_next: d=%h fe=%b want 11 0", d, frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 17; i++) begin
            exp = 8'(i);
            send_byte(exp, 1'b1);
            total++;
            if (fifo_almost_full !== (i + 1 >= 14)) begin
                bad++;
                $display("FAIL ovf_af n=%0d: got %b", i + 1, fifo_almost_full);
            end
            total++;
            if (fifo_full !== (i + 1 >= 16)) begin
                bad++;
                $display("FAIL ovf_full n=%0d: got %b", i + 1, fifo_full);
            end
            total++;
            if (overrun !== (i + 1 >= 17)) begin
                bad++;
                $display("FAIL ovf_overrun n=%0d: got %b", i + 1, overrun);
            end
        end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d);
            exp = 8'(i);
            total++;
            if (d !== exp) begin
                bad++;
                $display("FAIL ovf_pop%0d: got %h want %h", i, d, exp);
            end
        end
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL ovf_drained: e=%b f=%b want 1 0", fifo_empty, fifo_full);
        end
        pop_byte(d);
        total++;
        if (d !== 8'h0F || fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL pop_empty: d=%h e=%b want 0f 1", d, fifo_empty);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        logic [7:0] f0;
        f0 = 8'hF0;
        send_byte(8'h77, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk_50m);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            repeat (BIT) @(negedge clk_50m);
        end
        rx = f0[4];
        repeat (BIT / 2) @(negedge clk_50m);
        reset = 1'b1;
        repeat (3) @(negedge clk_50m);
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
            fifo_almost_full !== 1'b0 || overrun !== 1'b0 ||
            frame_err !== 1'b0 || fifo_data_out !== 8'h00) begin
            bad++;
            $display("FAIL midreset: e=%b f=%b af=%b o=%b fe=%b d=%h",
                     fifo_empty, fifo_full, fifo_almost_full,
                     overrun, frame_err, fifo_data_out);
        end
        reset = 1'b0;
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk_50m);
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL midreset_idle: e=%b want 1", fifo_empty);
        end
        send_byte(8'h81, 1'b1);
        pop_byte(d);
        total++;
        if (d !== 8'h81 || fifo_empty !== 1'b1 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_next: d=%h e=%b fe=%b want 81 1 0",
                     d, fifo_empty, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int c0, c1, e, lat;
        c0 = cyc;
        e  = -1;
        fork
            send_byte(8'h21, 1'b1);
            begin
                for (int k = 0; k < 11 * BIT; k++) begin
                    @(negedge clk_50m);
                    if (e < 0 && fifo_empty === 1'b0) e = cyc;
                end
            end
        join
        total++;
        if (e < 0) begin
            bad++;
            $display("FAIL b2b_first_push: got none want push");
            return;
        end
        lat = e - c0;
        while (((cyc - c0) % DIVT) != 0) @(negedge clk_50m);
        c1 = cyc;
        fork
            send_byte(8'h42, 1'b1);
            begin
                for (int k = 0; k < 11 * BIT; k++) begin
                    if (cyc == c1 + lat - 1) break;
                    @(negedge clk_50m);
                end
                fifo_rd_en = 1'b1;
                @(negedge clk_50m);
                fifo_rd_en = 1'b0;
                total++;
                if (fifo_data_out !== 8'h21 || fifo_empty !== 1'b0 ||
                    fifo_full !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_same_edge: d=%h e=%b f=%b want 21 0 0",
                             fifo_data_out, fifo_empty, fifo_full);
                end
            end
        join
        pop_byte(d);
        total++;
        if (d !== 8'h42) begin
            bad++;
            $display("FAIL b2b_second: got %h want 42", d);
        end
        total++;
        if (fifo_empty !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: e=%b o=%b want 1 0", fifo_empty, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
